state_code_sequencer: RTL and testbench

//  Generates the 2-bit state code curr_state consumed by the incomplete-state flag decoders, plus a

---
 rtl/state_code_sequencer_if.sv | 22 ++
 rtl/state_code_sequencer.sv | 143 ++++++++++++++
 tb/tb_state_code_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/state_code_sequencer_if.sv
// Handshake bundle for state_code_sequencer: control inputs and registered state/flag outputs.
interface state_code_sequencer_if;
    logic       start;
    logic       hold;
    logic       load_en;
    logic [1:0] load_state;
    logic [1:0] curr_state;
    logic [1:0] flag;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, hold, load_en, load_state,
        input  curr_state, flag, busy, done, err
    );

    modport slave (
        input  start, hold, load_en, load_state,
        output curr_state, flag, busy, done, err
    );
endinterface

// File: rtl/state_code_sequencer.sv
// IDLE->RUN->FLUSH->IDLE state-code sequencer with programmable dwells and a load override.
// Define SCS_ILLEGAL_TRAP_EN to let a load of code 2 appear for one cycle and set a sticky err.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting; start accepted once DWELL0 IDLE cycles have elapsed
//  S_RUN   | DWELL1-cycle pass, frozen while hold is high
//  S_ILL   | illegal code 2 (trap build only), returns to IDLE next cycle
//  S_FLUSH | DWELL3-cycle drain, then done pulse on return to IDLE
module state_code_sequencer #(
    parameter int DWELL_W = 4,
    parameter int DWELL0  = 2,
    parameter int DWELL1  = 4,
    parameter int DWELL3  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    state_code_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ILL   = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    localparam logic [DWELL_W-1:0] D0_M1 = DWELL_W'(DWELL0 - 1);
    localparam logic [DWELL_W-1:0] D1_M1 = DWELL_W'(DWELL1 - 1);
    localparam logic [DWELL_W-1:0] D3_M1 = DWELL_W'(DWELL3 - 1);
    localparam logic [DWELL_W-1:0] ONE   = DWELL_W'(1);

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               free_q, free_d;
    logic [1:0]         flag_q, flag_d;
    logic               busy_q;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // The IDLE counter holds (cycles already spent in IDLE - 1), so a start seen on
    // the DWELL0-th IDLE cycle is accepted. free_q marks the post-reset IDLE as already satisfied.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        free_d  = free_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (bus.load_en) begin
            free_d = 1'b0;
            case (bus.load_state)
                2'd1: begin
                    state_d = S_RUN;
                    cnt_d   = D1_M1;
                end
                2'd3: begin
                    state_d = S_FLUSH;
                    cnt_d   = D3_M1;
                end
                2'd2: begin
`ifdef SCS_ILLEGAL_TRAP_EN
                    state_d = S_ILL;
                    err_d   = 1'b1;
`else
                    state_d = S_IDLE;
`endif
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && (free_q || cnt_q >= D0_M1)) begin
                        state_d = S_RUN;
                        cnt_d   = D1_M1;
                        free_d  = 1'b0;
                    end else if (cnt_q < D0_M1) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_RUN: begin
                    if (!bus.hold) begin
                        if (cnt_q == '0) begin
                            state_d = S_FLUSH;
                            cnt_d   = D3_M1;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        flag_d = (state_d == S_FLUSH || state_d == S_ILL) ? 2'd0 : 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            free_q  <= 1'b1;
            flag_q  <= 2'd2;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            free_q  <= free_d;
            flag_q  <= flag_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.curr_state = state_q;
    assign bus.flag       = flag_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef SCS_ILLEGAL_TRAP_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_state_code_sequencer.sv
// Directed, table-driven bench for state_code_sequencer with default dwells (2/4/2).
module tb_state_code_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    state_code_sequencer_if sif ();

    state_code_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       start;
        logic       hold;
        logic       load_en;
        logic [1:0] ls;
        logic [1:0] st;
        logic [1:0] fl;
        logic       bz;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] fl,
                           input logic bz, input logic dn, input logic er);
        chk({tag, ".curr_state"}, int'(sif.curr_state), int'(st));
        chk({tag, ".flag"},       int'(sif.flag),       int'(fl));
        chk({tag, ".busy"},       int'(sif.busy),       int'(bz));
        chk({tag, ".done"},       int'(sif.done),       int'(dn));
        chk({tag, ".err"},        int'(sif.err),        int'(er));
    endtask

    task automatic drive(input logic s, input logic h, input logic le, input logic [1:0] ls);
        sif.start      = s;
        sif.hold       = h;
        sif.load_en    = le;
        sif.load_state = ls;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_err;
        bit   got_run;
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 2'd0);

        //            start hold ld  ls    st    fl    bz    dn
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0}); // start accepted right after reset
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0}); // first IDLE cycle: ignored
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0}); // second IDLE edge: accepted
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0}); // RUN with 3 hold cycles
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0}); // start in RUN ignored
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0}); // hold in FLUSH ignored
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0}); // load 3 beats start
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 1'b0}); // reload RUN restarts dwell
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0}); // reload FLUSH restarts dwell
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0}); // load 0 in FLUSH: no done
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0}); // IDLE dwell restarts after load
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0});

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk_all("reset", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].hold, vecs[i].load_en, vecs[i].ls);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].bz, vecs[i].dn, 1'b0);
        end

        // Illegal code load from RUN
        drive(1'b0, 1'b0, 1'b1, 2'd2);
        step();
`ifdef SCS_ILLEGAL_TRAP_EN
        exp_err = 1'b1;
        chk_all("load2", 2'd2, 2'd0, 1'b1, 1'b0, 1'b1);
`else
        exp_err = 1'b0;
        chk_all("load2", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
`endif
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        step();
        chk_all("load2_next", 2'd0, 2'd2, 1'b0, 1'b0, exp_err);
        step();
        chk_all("load2_sticky", 2'd0, 2'd2, 1'b0, 1'b0, exp_err);

        // Get into RUN (bounded), then async reset mid-cycle
        got_run = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        for (int n = 0; n < 8 && !got_run; n++) begin
            step();
            if (sif.curr_state == 2'd1) got_run = 1'b1;
        end
        chk("reach_run", int'(got_run), 1);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;

        // Clean restart after reset
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        step();
        chk_all("restart", 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        for (int n = 0; n < 3; n++) step();
        chk_all("restart_run_end", 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("restart_flush", 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk_all("restart_done", 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
